// File: rtl/elevator_scan_controller.sv
// Single-car SCAN elevator controller: latches floor calls, sweeps in one direction
// while requests remain ahead, opens the door at each requested floor, then reverses or idles.
module elevator_scan_controller #(
  parameter int NUM_FLOORS      = 5,
  parameter int TICKS_PER_FLOOR = 4,
  parameter int DOOR_TICKS      = 3,
  localparam int FLOOR_W        = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_tick,
  input  logic                  i_hold,
  input  logic [NUM_FLOORS-1:0] i_call,
  output logic [FLOOR_W-1:0]    o_floor,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_motor_up,
  output logic                  o_motor_down,
  output logic                  o_door_open,
  output logic                  o_dir,
  output logic [2:0]            o_state_value
);

  localparam int TRAVEL_W = (TICKS_PER_FLOOR > 1) ? $clog2(TICKS_PER_FLOOR) : 1;
  localparam int DOOR_W   = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TICKS_PER_FLOOR - 1);
  localparam logic [DOOR_W-1:0]   DOOR_LAST   = DOOR_W'(DOOR_TICKS - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_UP   = 3'd1;
  localparam logic [2:0] ST_DOWN = 3'd2;
  localparam logic [2:0] ST_DOOR = 3'd3;

  logic [2:0]            r_state, w_state_next;
  logic [FLOOR_W-1:0]    r_floor, w_floor_next;
  logic [NUM_FLOORS-1:0] r_pending, w_pending_next;
  logic [NUM_FLOORS-1:0] w_call_eff, w_clear, w_floor_onehot;
  logic                  r_dir, w_dir_next;
  logic [TRAVEL_W-1:0]   r_travel, w_travel_next;
  logic [DOOR_W-1:0]     r_door, w_door_next;
  logic                  r_motor_up, r_motor_down, r_door_open;
  logic                  w_here, w_above, w_below;
  logic                  w_here_up, w_here_dn, w_above_nxt, w_below_nxt;
  logic                  w_go_up, w_go_down, w_step;
  logic                  w_clear_en;
  logic [FLOOR_W-1:0]    w_clear_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_onehot
      assign w_floor_onehot[gi] = (r_floor == FLOOR_W'(gi));
    end
  endgenerate

  // Request geometry relative to the current floor and to the floor one step away.
  always_comb begin
    w_here      = 1'b0;
    w_above     = 1'b0;
    w_below     = 1'b0;
    w_here_up   = 1'b0;
    w_here_dn   = 1'b0;
    w_above_nxt = 1'b0;
    w_below_nxt = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (r_pending[i]) begin
        if (i == int'(r_floor))     w_here      = 1'b1;
        if (i >  int'(r_floor))     w_above     = 1'b1;
        if (i <  int'(r_floor))     w_below     = 1'b1;
        if (i == int'(r_floor) + 1) w_here_up   = 1'b1;
        if (i == int'(r_floor) - 1) w_here_dn   = 1'b1;
        if (i >  int'(r_floor) + 1) w_above_nxt = 1'b1;
        if (i <  int'(r_floor) - 1) w_below_nxt = 1'b1;
      end
    end
  end

  assign w_go_up   = w_above && (r_dir || !w_below);
  assign w_go_down = w_below && (!r_dir || !w_above);
  assign w_step    = i_tick && !i_hold;

  always_comb begin
    w_state_next  = r_state;
    w_floor_next  = r_floor;
    w_dir_next    = r_dir;
    w_travel_next = r_travel;
    w_door_next   = r_door;
    w_clear_en    = 1'b0;
    w_clear_idx   = r_floor;
    case (r_state)
      ST_IDLE: begin
        if (w_here) begin
          w_state_next = ST_DOOR;
          w_clear_en   = 1'b1;
          w_door_next  = '0;
        end else if (w_go_up) begin
          w_state_next  = ST_UP;
          w_dir_next    = 1'b1;
          w_travel_next = '0;
        end else if (w_below) begin
          w_state_next  = ST_DOWN;
          w_dir_next    = 1'b0;
          w_travel_next = '0;
        end
      end
      ST_UP: begin
        if (w_step) begin
          if (r_travel == TRAVEL_LAST) begin
            w_travel_next = '0;
            w_floor_next  = r_floor + FLOOR_W'(1);
            if (w_here_up) begin
              w_state_next = ST_DOOR;
              w_clear_en   = 1'b1;
              w_clear_idx  = r_floor + FLOOR_W'(1);
              w_door_next  = '0;
            end else if (!w_above_nxt) begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_travel_next = r_travel + TRAVEL_W'(1);
          end
        end
      end
      ST_DOWN: begin
        if (w_step) begin
          if (r_travel == TRAVEL_LAST) begin
            w_travel_next = '0;
            w_floor_next  = r_floor - FLOOR_W'(1);
            if (w_here_dn) begin
              w_state_next = ST_DOOR;
              w_clear_en   = 1'b1;
              w_clear_idx  = r_floor - FLOOR_W'(1);
              w_door_next  = '0;
            end else if (!w_below_nxt) begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_travel_next = r_travel + TRAVEL_W'(1);
          end
        end
      end
      ST_DOOR: begin
        // A fresh press at the open floor, or a hold, keeps the door open from scratch.
        if ((i_call & w_floor_onehot) != '0 || i_hold) begin
          w_door_next = '0;
        end else if (i_tick) begin
          if (r_door == DOOR_LAST) begin
            if (w_go_up) begin
              w_state_next  = ST_UP;
              w_dir_next    = 1'b1;
              w_travel_next = '0;
            end else if (w_go_down) begin
              w_state_next  = ST_DOWN;
              w_dir_next    = 1'b0;
              w_travel_next = '0;
            end else begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_door_next = r_door + DOOR_W'(1);
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_clear        = w_clear_en ? (NUM_FLOORS'(1) << w_clear_idx) : '0;
  assign w_call_eff     = (r_state == ST_DOOR) ? (i_call & ~w_floor_onehot) : i_call;
  assign w_pending_next = (r_pending | w_call_eff) & ~w_clear;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_floor      <= '0;
      r_pending    <= '0;
      r_dir        <= 1'b1;
      r_travel     <= '0;
      r_door       <= '0;
      r_motor_up   <= 1'b0;
      r_motor_down <= 1'b0;
      r_door_open  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_floor      <= w_floor_next;
      r_pending    <= w_pending_next;
      r_dir        <= w_dir_next;
      r_travel     <= w_travel_next;
      r_door       <= w_door_next;
      r_motor_up   <= (w_state_next == ST_UP) && !i_hold;
      r_motor_down <= (w_state_next == ST_DOWN) && !i_hold;
      r_door_open  <= (w_state_next == ST_DOOR);
    end
  end

  assign o_floor       = r_floor;
  assign o_pending     = r_pending;
  assign o_motor_up    = r_motor_up;
  assign o_motor_down  = r_motor_down;
  assign o_door_open   = r_door_open;
  assign o_dir         = r_dir;
  assign o_state_value = r_state;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Scenario bench for elevator_scan_controller: door-open floors are queued as stimulus is
// applied and checked in order as the car opens its door; timing points are checked inline.
module tb_elevator_scan_controller;

  localparam int ST_IDLE = 0;
  localparam int ST_UP   = 1;
  localparam int ST_DOWN = 2;
  localparam int ST_DOOR = 3;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_tick;
  logic       i_hold;
  logic [4:0] i_call;
  logic [2:0] o_floor;
  logic [4:0] o_pending;
  logic       o_motor_up, o_motor_down, o_door_open, o_dir;
  logic [2:0] o_state_value;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int down_cycles = 0;
  int tick_mode = 0;
  logic door_prev = 1'b0;
  int q_exp[$];

  elevator_scan_controller dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_tick       (i_tick),
    .i_hold       (i_hold),
    .i_call       (i_call),
    .o_floor      (o_floor),
    .o_pending    (o_pending),
    .o_motor_up   (o_motor_up),
    .o_motor_down (o_motor_down),
    .o_door_open  (o_door_open),
    .o_dir        (o_dir),
    .o_state_value(o_state_value)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  assign i_tick = (tick_mode == 0) ? 1'b1 : ((cyc % 3) == 0);

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Door-open events are the scoreboard's transactions.
  always @(negedge i_clk) begin
    check("motor_excl", int'(o_motor_up & o_motor_down), 0);
    if (o_motor_down) down_cycles <= down_cycles + 1;
    if (o_door_open && !door_prev) begin
      if (q_exp.size() == 0) begin
        check("door_unexpected", int'(o_floor), -1);
      end else begin
        int exp_floor;
        exp_floor = q_exp.pop_front();
        $display("[TB] door open at floor %0d, expected floor %0d", o_floor, exp_floor);
        check("door_floor", int'(o_floor), exp_floor);
      end
    end
    door_prev <= o_door_open;
  end

  task automatic wait_fs(input string tag, input int f, input int st, input int budget,
                         output int n);
    n = 0;
    while (!(int'(o_floor) == f && int'(o_state_value) == st) && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    check({tag, "_timeout"}, int'(n >= budget), 0);
  endtask

  task automatic door_len(input string tag, output int len);
    len = 0;
    while (o_door_open && len < 40) begin
      len++;
      @(negedge i_clk);
    end
    check({tag, "_timeout"}, int'(len >= 40), 0);
  endtask

  task automatic pulse_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t0;
    i_rst_n = 1'b0;
    i_hold  = 1'b0;
    i_call  = '0;
    repeat (3) @(negedge i_clk);

    // Reset state
    check("rst_floor", int'(o_floor), 0);
    check("rst_pending", int'(o_pending), 0);
    check("rst_state", int'(o_state_value), ST_IDLE);
    check("rst_dir", int'(o_dir), 1);
    check("rst_motors", int'({o_motor_up, o_motor_down, o_door_open}), 0);
    i_rst_n = 1'b1;

    // Single call to floor 3
    @(negedge i_clk);
    i_call = 5'b01000;
    q_exp.push_back(3);
    @(negedge i_clk);
    i_call = '0;
    check("r29_pending", int'(o_pending), 8);
    check("r29_still_idle", int'(o_state_value), ST_IDLE);
    @(negedge i_clk);
    check("r29_move_up", int'(o_state_value), ST_UP);
    check("r29_motor_up", int'(o_motor_up), 1);
    wait_fs("r29_travel", 3, ST_DOOR, 40, n);
    check("r29_travel_cycles", n, 12);
    check("r29_pending_clr", int'(o_pending), 0);
    door_len("r29_door", n);
    check("r29_door_len", n, 3);
    check("r29_idle", int'(o_state_value), ST_IDLE);

    // Call at the current floor while idle, then a re-press while the door is open
    i_call = 5'b01000;
    q_exp.push_back(3);
    @(negedge i_clk);
    i_call = '0;
    @(negedge i_clk);
    check("r33_door_here", int'(o_state_value), ST_DOOR);
    check("r33_no_motion", int'({o_motor_up, o_motor_down}), 0);
    check("r33_floor", int'(o_floor), 3);
    i_call = 5'b01000;
    @(negedge i_clk);
    i_call = '0;
    check("r16_no_latch", int'(o_pending), 0);
    door_len("r16_restart", n);
    check("r16_restart_len", n, 3);
    check("sb_empty_a", q_exp.size(), 0);

    // Two calls upward: stop at 2 then 4, never driving down
    pulse_reset();
    check("rst2_floor", int'(o_floor), 0);
    t0 = down_cycles;
    i_call = 5'b10100;
    q_exp.push_back(2);
    q_exp.push_back(4);
    @(negedge i_clk);
    i_call = '0;
    wait_fs("r30_f2", 2, ST_DOOR, 40, n);
    check("r30_dir_f2", int'(o_dir), 1);
    check("r30_pending_f2", int'(o_pending), 16);
    wait_fs("r30_f4", 4, ST_DOOR, 60, n);
    check("r30_no_reverse", down_cycles - t0, 0);
    wait_fs("r30_idle", 4, ST_IDLE, 20, n);
    check("r30_pending_end", int'(o_pending), 0);

    // Call behind the car: finish the upward sweep before reversing
    pulse_reset();
    i_call = 5'b10000;
    q_exp.push_back(4);
    @(negedge i_clk);
    i_call = '0;
    wait_fs("r31_f2", 2, ST_UP, 40, n);
    i_call = 5'b00010;
    q_exp.push_back(1);
    @(negedge i_clk);
    i_call = '0;
    check("r31_pending", int'(o_pending), 18);
    wait_fs("r31_f4", 4, ST_DOOR, 40, n);
    wait_fs("r31_f1", 1, ST_DOOR, 60, n);
    check("r31_dir_down", int'(o_dir), 0);
    wait_fs("r31_idle", 1, ST_IDLE, 20, n);

    // Hold mid-travel, then hold with the door open
    i_call = 5'b01000;
    q_exp.push_back(3);
    @(negedge i_clk);
    i_call = '0;
    @(negedge i_clk);
    check("r32_up", int'(o_state_value), ST_UP);
    repeat (2) @(negedge i_clk);
    i_hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check("r32_hold_motor", int'({o_motor_up, o_motor_down}), 0);
      check("r32_hold_floor", int'(o_floor), 1);
      check("r32_hold_state", int'(o_state_value), ST_UP);
    end
    i_hold = 1'b0;
    wait_fs("r32_resume", 2, ST_UP, 20, n);
    check("r32_remaining", n, 2);
    check("r32_motor_back", int'(o_motor_up), 1);
    wait_fs("r32_f3", 3, ST_DOOR, 20, n);
    check("r32_next_floor", n, 4);
    i_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      check("r32_hold_door", int'(o_door_open), 1);
    end
    i_hold = 1'b0;
    door_len("r32_door", n);
    check("r32_door_after_hold", n, 3);

    // Slow time base: one tick every third cycle
    tick_mode = 1;
    i_call = 5'b00001;
    q_exp.push_back(0);
    @(negedge i_clk);
    i_call = '0;
    wait_fs("r33_f2", 2, ST_DOWN, 100, n);
    t0 = cyc;
    wait_fs("r33_f1", 1, ST_DOWN, 100, n);
    check("r33_spacing", cyc - t0, 12);
    wait_fs("r33_f0", 0, ST_DOOR, 100, n);
    wait_fs("r33_idle", 0, ST_IDLE, 60, n);
    tick_mode = 0;
    check("sb_empty_b", q_exp.size(), 0);

    // Asynchronous reset in the middle of travel
    @(negedge i_clk);
    i_call = 5'b10000;
    @(negedge i_clk);
    i_call = '0;
    wait_fs("r34_f2", 2, ST_UP, 40, n);
    i_call = 5'b00001;
    @(negedge i_clk);
    i_call = '0;
    check("r34_pending", int'(o_pending), 17);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("r34_async_motor", int'({o_motor_up, o_motor_down, o_door_open}), 0);
    check("r34_async_pending", int'(o_pending), 0);
    check("r34_async_floor", int'(o_floor), 0);
    check("r34_async_state", int'(o_state_value), ST_IDLE);
    check("r34_async_dir", int'(o_dir), 1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    check("r34_post_floor", int'(o_floor), 0);
    check("r34_post_state", int'(o_state_value), ST_IDLE);
    check("r34_post_pending", int'(o_pending), 0);
    check("sb_empty_end", q_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_scan_controller.md
ELEVATOR_SCAN_CONTROLLER -- requirements
Module: elevator_scan_controller

Interface
REQ-001 Parameter NUM_FLOORS, default 5, number of served floors (2..16).
REQ-002 Parameter TICKS_PER_FLOOR, default 4, tick pulses needed to travel one floor (>=1).
REQ-003 Parameter DOOR_TICKS, default 3, tick pulses the door stays open (>=1).
REQ-004 Derived FLOOR_W = max(1, clog2(NUM_FLOORS)).
REQ-005 CLK  input  1  system clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
REQ-007 tick  input  1  single-cycle time-base enable; travel and door counters advance only when tick=1.
REQ-008 hold  input  1  freeze request: suspends travel, keeps door open.
REQ-009 call  input  NUM_FLOORS  per-floor call buttons, level-sampled every cycle.
REQ-010 floor  output  FLOOR_W  current floor index.
REQ-011 pending  output  NUM_FLOORS  latched outstanding requests.
REQ-012 motor_up / motor_down  output  1 each  motor drive; never both 1.
REQ-013 door_open  output  1  door open indicator.
REQ-014 dir  output  1  last travel direction, 1=up, 0=down.
REQ-015 state_value  output  3  FSM state: IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR=3; other codes unused.

Function
REQ-016 pending[i] SHALL set the cycle after call[i]=1 and stay set until served; exception: call[i] while state=DOOR and floor=i is not latched and restarts the door counter.
REQ-017 "above"/"below" SHALL mean any pending bit at index >floor / <floor.
REQ-018 IDLE: pending[floor]=1 -> DOOR and clear pending[floor]; else above && (dir=1 || !below) -> MOVE_UP; else below -> MOVE_DOWN; else stay. Decision uses registered pending (call-to-move latency 2 cycles).
REQ-019 MOVE_UP/MOVE_DOWN: motor_up/motor_down=1 respectively, dir set to 1/0; travel counter increments on tick; on reaching TICKS_PER_FLOOR it clears and floor changes by +1/-1 in the same cycle.
REQ-020 On a floor change, if pending[new floor]=1 the FSM SHALL enter DOOR next edge and clear that bit; else continue same direction.
REQ-021 floor SHALL never exceed NUM_FLOORS-1 nor go below 0; if no request remains in the travel direction at a floor change, go to DOOR if pending[floor] else IDLE (no overshoot).
REQ-022 DOOR: door_open=1, motors 0; door counter increments on tick; after DOOR_TICKS ticks: requests in dir -> continue dir; else requests opposite -> reverse; else IDLE.
REQ-023 hold=1 SHALL freeze travel counter and force both motor outputs 0 in MOVE states (state, floor unchanged); in DOOR it holds door counter at 0; in IDLE no effect; calls still latch during hold.
REQ-024 tick=0 SHALL freeze all counters; floor only changes on a tick cycle.
REQ-025 Simultaneous set/clear of the same pending bit: clear wins, call is considered served.
REQ-026 All outputs registered or decoded from registered state only; no combinational path from call/hold to motor outputs.

Reset
REQ-027 reset=0 SHALL immediately force state IDLE, floor 0, pending 0, dir 1, counters 0, motor_up=motor_down=door_open=0, state_value=0.
REQ-028 Reset mid-travel or mid-door SHALL discard all requests; operation resumes from floor 0 on first edge after release.

Verification (defaults, tick=1 every cycle unless stated)
REQ-029 Reset release, call[3] pulse one cycle -> pending=01000 next cycle, MOVE_UP next, floor 3 after 12 tick cycles, DOOR 3 ticks, pending=0, IDLE.
REQ-030 At floor 0 calls 2 and 4 together -> stops at 2 (DOOR), then 4; no reversal between.
REQ-031 Moving up past 1 toward 4, call[1] arrives -> continue to 4, DOOR, then reverse to 1.
REQ-032 hold=1 for 5 cycles mid-travel -> motors 0, floor and travel counter frozen, resumes exact remaining ticks; hold in DOOR -> door_open stays 1 for hold duration plus 3 ticks.
REQ-033 tick every 3rd cycle -> floor change spacing 12 cycles; call at current floor in IDLE -> DOOR with no motion.
REQ-034 reset=0 asserted mid-move at floor 2 with pending 10001 -> outputs zero asynchronously, pending=0, floor 0 after release.
